// File: rtl/axi_rr_pkg.sv
// Shared types and constants for the AXI read-response router.
package axi_rr_pkg;

  localparam int RR_NUM_MST = 3;
  localparam int RR_NUM_SLV = 8;
  localparam int RR_DATA_W  = 32;
  localparam int RR_ID_W    = 4;
  localparam int RR_LEN_W   = 4;
  localparam int RR_MST_W   = 2;
  localparam int RR_SLV_W   = 4;

  localparam logic [RR_SLV_W-1:0] SLV_NONE    = 4'hF;
  localparam logic [1:0]          RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, FWD, DERR} rr_state_e;

  typedef struct packed {
    logic [RR_MST_W-1:0] mst;
    logic [RR_SLV_W-1:0] slv;
    logic [RR_LEN_W-1:0] len;
    logic [RR_ID_W-1:0]  id;
  } rr_ctx_t;

  function automatic rr_ctx_t make_ctx(input logic [RR_MST_W-1:0] mst,
                                       input logic [RR_SLV_W-1:0] slv,
                                       input logic [RR_LEN_W-1:0] len,
                                       input logic [RR_ID_W-1:0]  id);
    make_ctx = '{mst, slv, len, id};
  endfunction

endpackage

// File: rtl/axi_rr_default_slave.sv
// Default-slave beat generator: emits DECERR beats for an undecoded read burst.
module axi_rr_default_slave
  import axi_rr_pkg::*;
#(
  parameter int DATA_W = RR_DATA_W,
  parameter int ID_W   = RR_ID_W,
  parameter int LEN_W  = RR_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic              rready,
  input  logic [LEN_W-1:0]  len,
  input  logic [ID_W-1:0]   id,
  output logic              rvalid,
  output logic              rlast,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              done
);

  logic [LEN_W-1:0] cnt_q, cnt_d;

  // Beat counter restarts at zero whenever the generator is idle.
  always_comb begin
    cnt_d = cnt_q;
    if (!active) begin
      cnt_d = '0;
    end else if (rready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rvalid = active;
  assign rlast  = active && (cnt_q == len);
  assign rid    = active ? id : '0;
  assign rdata  = '0;
  assign rresp  = active ? RESP_DECERR : 2'b00;
  assign done   = active && rready && (cnt_q == len);

endmodule

// File: rtl/axi_read_resp_router.sv
// R-channel return router: routes one granted read burst slave->master, or serves DECERR.
// Optional feature macro: BURST_CHECK_EN (ARLEN vs RLAST checking in FWD, adds len_err).
module axi_read_resp_router
  import axi_rr_pkg::*;
#(
  parameter int NUM_MST = RR_NUM_MST,
  parameter int NUM_SLV = RR_NUM_SLV,
  parameter int DATA_W  = RR_DATA_W,
  parameter int ID_W    = RR_ID_W,
  parameter int LEN_W   = RR_LEN_W
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      grant_valid,
  input  logic [1:0]                grant_mst,
  input  logic [3:0]                grant_slv,
  input  logic                      ar_hs,
  input  logic [LEN_W-1:0]          ar_len,
  input  logic [ID_W-1:0]           ar_id,
  output logic                      ds_arready,
  input  logic [NUM_SLV*(ID_W+4)-1:0] RID_S,
  input  logic [NUM_SLV*DATA_W-1:0] RDATA_S,
  input  logic [NUM_SLV*2-1:0]      RRESP_S,
  input  logic [NUM_SLV-1:0]        RLAST_S,
  input  logic [NUM_SLV-1:0]        RVALID_S,
  output logic [NUM_SLV-1:0]        RREADY_S,
  output logic [NUM_MST*ID_W-1:0]   RID_M,
  output logic [NUM_MST*DATA_W-1:0] RDATA_M,
  output logic [NUM_MST*2-1:0]      RRESP_M,
  output logic [NUM_MST-1:0]        RLAST_M,
  output logic [NUM_MST-1:0]        RVALID_M,
  input  logic [NUM_MST-1:0]        RREADY_M,
  output logic                      rd_done,
`ifdef BURST_CHECK_EN
  output logic                      len_err,
`endif
  output logic                      busy
);

  rr_state_e state_q, state_d;
  rr_ctx_t   ctx_q, ctx_d;

  logic              sel_rvalid, sel_rlast, sel_rready;
  logic [ID_W+3:0]   sel_rid;
  logic [DATA_W-1:0] sel_rdata;
  logic [1:0]        sel_rresp;
  logic              fwd_hs, fwd_last;

  logic              ds_active, ds_rvalid, ds_rlast, ds_done;
  logic [ID_W-1:0]   ds_rid;
  logic [DATA_W-1:0] ds_rdata;
  logic [1:0]        ds_rresp;

  logic              ds_arready_c, done_c;
  logic              m_valid, m_last, s_ready;
  logic [ID_W-1:0]   m_rid;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;

  logic unused_rid_mst;

  // Pick out the owning slave's R channel and the owning master's RREADY.
  always_comb begin
    sel_rvalid = 1'b0;
    sel_rlast  = 1'b0;
    sel_rid    = '0;
    sel_rdata  = '0;
    sel_rresp  = '0;
    sel_rready = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (ctx_q.slv == 4'(i)) begin
        sel_rvalid = RVALID_S[i];
        sel_rlast  = RLAST_S[i];
        sel_rid    = RID_S[i*(ID_W+4) +: (ID_W+4)];
        sel_rdata  = RDATA_S[i*DATA_W +: DATA_W];
        sel_rresp  = RRESP_S[i*2 +: 2];
      end
    end
    for (int j = 0; j < NUM_MST; j++) begin
      if (ctx_q.mst == 2'(j)) begin
        sel_rready = RREADY_M[j];
      end
    end
  end

  // Upper RID bits carry the master index, already known from the context.
  assign unused_rid_mst = ^sel_rid[ID_W+3:ID_W];

  assign fwd_hs    = (state_q == FWD) && sel_rvalid && sel_rready;
  assign ds_active = (state_q == DERR);

  axi_rr_default_slave #(
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .LEN_W  (LEN_W)
  ) u_default_slave (
    .clk    (ACLK),
    .reset  (ARESET),
    .active (ds_active),
    .rready (sel_rready),
    .len    (ctx_q.len),
    .id     (ctx_q.id),
    .rvalid (ds_rvalid),
    .rlast  (ds_rlast),
    .rid    (ds_rid),
    .rdata  (ds_rdata),
    .rresp  (ds_rresp),
    .done   (ds_done)
  );

`ifdef BURST_CHECK_EN
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             len_err_q, len_err_d;
  logic             at_len;

  assign at_len   = (cnt_q == ctx_q.len);
  assign fwd_last = sel_rlast | at_len;

  // Any disagreement between ARLEN and the slave's RLAST is latched until reset.
  always_comb begin
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
    if (state_q != FWD) begin
      cnt_d = '0;
    end else if (fwd_hs) begin
      cnt_d = cnt_q + 1'b1;
      if (sel_rlast != at_len) begin
        len_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  assign len_err = len_err_q;
`else
  assign fwd_last = sel_rlast;
`endif

  always_comb begin
    state_d      = state_q;
    ctx_d        = ctx_q;
    ds_arready_c = 1'b0;
    done_c       = 1'b0;
    m_valid      = 1'b0;
    m_last       = 1'b0;
    m_rid        = '0;
    m_rdata      = '0;
    m_rresp      = '0;
    s_ready      = 1'b0;
    case (state_q)
      IDLE: begin
        ds_arready_c = grant_valid && (grant_slv == SLV_NONE);
        if (grant_valid && ar_hs && (grant_slv != SLV_NONE)) begin
          ctx_d   = make_ctx(grant_mst, grant_slv, ar_len, ar_id);
          state_d = FWD;
        end else if (ds_arready_c) begin
          ctx_d   = make_ctx(grant_mst, grant_slv, ar_len, ar_id);
          state_d = DERR;
        end
      end
      FWD: begin
        m_valid = sel_rvalid;
        m_last  = fwd_last;
        m_rid   = sel_rid[ID_W-1:0];
        m_rdata = sel_rdata;
        m_rresp = sel_rresp;
        s_ready = sel_rready;
        if (fwd_hs && fwd_last) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      DERR: begin
        m_valid = ds_rvalid;
        m_last  = ds_rlast;
        m_rid   = ds_rid;
        m_rdata = ds_rdata;
        m_rresp = ds_rresp;
        if (ds_done) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      ctx_q   <= '0;
    end else begin
      state_q <= state_d;
      ctx_q   <= ctx_d;
    end
  end

  // Reset suppresses every handshake-visible output in the same cycle it is asserted.
  always_comb begin
    RVALID_M = '0;
    RLAST_M  = '0;
    RID_M    = '0;
    RDATA_M  = '0;
    RRESP_M  = '0;
    RREADY_S = '0;
    if (!ARESET) begin
      for (int j = 0; j < NUM_MST; j++) begin
        if (ctx_q.mst == 2'(j)) begin
          RVALID_M[j]                 = m_valid;
          RLAST_M[j]                  = m_last;
          RID_M[j*ID_W +: ID_W]       = m_rid;
          RDATA_M[j*DATA_W +: DATA_W] = m_rdata;
          RRESP_M[j*2 +: 2]           = m_rresp;
        end
      end
      for (int i = 0; i < NUM_SLV; i++) begin
        if (ctx_q.slv == 4'(i)) begin
          RREADY_S[i] = s_ready;
        end
      end
    end
  end

  assign ds_arready = ds_arready_c && !ARESET;
  assign rd_done    = done_c && !ARESET;
  assign busy       = (state_q != IDLE) && !ARESET;

endmodule

// File: tb/tb_axi_read_resp_router.sv
// Directed self-checking bench for axi_read_resp_router (BURST_CHECK_EN section when defined).
module tb_axi_read_resp_router;

  localparam int NUM_MST = 3;
  localparam int NUM_SLV = 8;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 4;
  localparam int LEN_W   = 4;

  logic                        ACLK;
  logic                        ARESET;
  logic                        grant_valid;
  logic [1:0]                  grant_mst;
  logic [3:0]                  grant_slv;
  logic                        ar_hs;
  logic [LEN_W-1:0]            ar_len;
  logic [ID_W-1:0]             ar_id;
  logic                        ds_arready;
  logic [NUM_SLV*(ID_W+4)-1:0] RID_S;
  logic [NUM_SLV*DATA_W-1:0]   RDATA_S;
  logic [NUM_SLV*2-1:0]        RRESP_S;
  logic [NUM_SLV-1:0]          RLAST_S;
  logic [NUM_SLV-1:0]          RVALID_S;
  logic [NUM_SLV-1:0]          RREADY_S;
  logic [NUM_MST*ID_W-1:0]     RID_M;
  logic [NUM_MST*DATA_W-1:0]   RDATA_M;
  logic [NUM_MST*2-1:0]        RRESP_M;
  logic [NUM_MST-1:0]          RLAST_M;
  logic [NUM_MST-1:0]          RVALID_M;
  logic [NUM_MST-1:0]          RREADY_M;
  logic                        rd_done;
  logic                        busy;
`ifdef BURST_CHECK_EN
  logic                        len_err;
`endif

  int compareCount  = 0;
  int mismatchCount = 0;

  axi_read_resp_router dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .grant_valid (grant_valid),
    .grant_mst   (grant_mst),
    .grant_slv   (grant_slv),
    .ar_hs       (ar_hs),
    .ar_len      (ar_len),
    .ar_id       (ar_id),
    .ds_arready  (ds_arready),
    .RID_S       (RID_S),
    .RDATA_S     (RDATA_S),
    .RRESP_S     (RRESP_S),
    .RLAST_S     (RLAST_S),
    .RVALID_S    (RVALID_S),
    .RREADY_S    (RREADY_S),
    .RID_M       (RID_M),
    .RDATA_M     (RDATA_M),
    .RRESP_M     (RRESP_M),
    .RLAST_M     (RLAST_M),
    .RVALID_M    (RVALID_M),
    .RREADY_M    (RREADY_M),
    .rd_done     (rd_done),
`ifdef BURST_CHECK_EN
    .len_err     (len_err),
`endif
    .busy        (busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic nextCycle();
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one beat on slave s's R channel.
  task automatic applyStimulus(input int s, input logic v, input logic [31:0] d, input logic l, input logic [7:0] rid);
    RVALID_S[s]                 = v;
    RDATA_S[s*DATA_W +: DATA_W] = d;
    RLAST_S[s]                  = l;
    RID_S[s*8 +: 8]             = rid;
    RRESP_S[s*2 +: 2]           = 2'b00;
  endtask

  task automatic grantRead(input logic [1:0] m, input logic [3:0] s, input logic [3:0] len, input logic [3:0] id);
    grant_valid = 1'b1;
    ar_hs       = 1'b1;
    grant_mst   = m;
    grant_slv   = s;
    ar_len      = len;
    ar_id       = id;
  endtask

  task automatic dropGrant();
    grant_valid = 1'b0;
    ar_hs       = 1'b0;
    grant_mst   = '0;
    grant_slv   = '0;
    ar_len      = '0;
    ar_id       = '0;
  endtask

  initial begin
    ARESET   = 1'b1;
    RID_S    = '0;
    RDATA_S  = '0;
    RRESP_S  = '0;
    RLAST_S  = '0;
    RVALID_S = '0;
    RREADY_M = '0;
    dropGrant();
    nextCycle();
    nextCycle();
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_rvalid_m", 64'(RVALID_M), 64'd0);
    checkOutput("rst_rready_s", 64'(RREADY_S), 64'd0);
    checkOutput("rst_rd_done", 64'(rd_done), 64'd0);
    checkOutput("rst_ds_arready", 64'(ds_arready), 64'd0);
    ARESET = 1'b0;

    // M0 -> S1, len=3, four beats
    $display("[TB] M0->S1 len=3 burst");
    grantRead(2'd0, 4'd1, 4'd3, 4'h2);
    applyStimulus(1, 1'b1, 32'hA000_0000, 1'b0, 8'h02);
    RREADY_M = 3'b111;
    settle();
    checkOutput("t1_idle_ds_arready", 64'(ds_arready), 64'd0);
    checkOutput("t1_idle_no_route", 64'(RREADY_S), 64'd0);
    nextCycle();
    dropGrant();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1'b1, 32'hA000_0000 + 32'(k), (k == 3), 8'h02);
      settle();
      checkOutput($sformatf("t1_rvalid_b%0d", k), 64'(RVALID_M), 64'h1);
      checkOutput($sformatf("t1_rdata_b%0d", k), 64'(RDATA_M[31:0]), 64'hA000_0000 + 64'(k));
      checkOutput($sformatf("t1_rlast_b%0d", k), 64'(RLAST_M), (k == 3) ? 64'h1 : 64'h0);
      checkOutput($sformatf("t1_rd_done_b%0d", k), 64'(rd_done), (k == 3) ? 64'h1 : 64'h0);
      checkOutput($sformatf("t1_rready_s_b%0d", k), 64'(RREADY_S), 64'h02);
      checkOutput($sformatf("t1_rid_b%0d", k), 64'(RID_M[3:0]), 64'h2);
      nextCycle();
    end
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 8'h00);
    settle();
    checkOutput("t1_end_busy", 64'(busy), 64'd0);
    checkOutput("t1_end_rvalid", 64'(RVALID_M), 64'd0);

    // M1 -> S5, len=1, master stalls three cycles on beat 0
    $display("[TB] M1->S5 len=1 with master stall");
    grantRead(2'd1, 4'd5, 4'd1, 4'h9);
    settle();
    nextCycle();
    dropGrant();
    RREADY_M = 3'b101;
    applyStimulus(5, 1'b1, 32'hB000_0000, 1'b0, 8'h19);
    for (int k = 0; k < 3; k++) begin
      settle();
      checkOutput($sformatf("t2_stall_rready_s%0d", k), 64'(RREADY_S), 64'd0);
      checkOutput($sformatf("t2_stall_rvalid%0d", k), 64'(RVALID_M), 64'h2);
      checkOutput($sformatf("t2_stall_rdata%0d", k), 64'(RDATA_M[63:32]), 64'hB000_0000);
      nextCycle();
    end
    RREADY_M = 3'b111;
    settle();
    checkOutput("t2_b0_rready_s", 64'(RREADY_S), 64'h20);
    checkOutput("t2_b0_rd_done", 64'(rd_done), 64'd0);
    nextCycle();
    applyStimulus(5, 1'b1, 32'hB000_0001, 1'b1, 8'h19);
    settle();
    checkOutput("t2_b1_rlast", 64'(RLAST_M), 64'h2);
    checkOutput("t2_b1_rd_done", 64'(rd_done), 64'd1);
    checkOutput("t2_b1_rid", 64'(RID_M[7:4]), 64'h9);
    nextCycle();
    applyStimulus(5, 1'b0, 32'h0, 1'b0, 8'h00);
    settle();
    checkOutput("t2_end_busy", 64'(busy), 64'd0);

    // M2 -> decode miss, id=7, len=2
    $display("[TB] M2 default-slave DECERR len=2");
    RREADY_M = 3'b000;
    grantRead(2'd2, 4'hF, 4'd2, 4'h7);
    settle();
    checkOutput("t3_ds_arready", 64'(ds_arready), 64'd1);
    nextCycle();
    dropGrant();
    settle();
    checkOutput("t3_derr_ds_arready", 64'(ds_arready), 64'd0);
    checkOutput("t3_derr_busy", 64'(busy), 64'd1);
    checkOutput("t3_derr_rvalid", 64'(RVALID_M), 64'h4);
    checkOutput("t3_derr_rlast_b0", 64'(RLAST_M), 64'd0);
    nextCycle();
    settle();
    checkOutput("t3_hold_rvalid", 64'(RVALID_M), 64'h4);
    checkOutput("t3_hold_rlast", 64'(RLAST_M), 64'd0);
    RREADY_M = 3'b100;
    for (int k = 0; k < 3; k++) begin
      settle();
      checkOutput($sformatf("t3_rresp_b%0d", k), 64'(RRESP_M), 64'h30);
      checkOutput($sformatf("t3_rdata_b%0d", k), 64'(RDATA_M[95:64]), 64'd0);
      checkOutput($sformatf("t3_rid_b%0d", k), 64'(RID_M[11:8]), 64'h7);
      checkOutput($sformatf("t3_rlast_b%0d", k), 64'(RLAST_M), (k == 2) ? 64'h4 : 64'h0);
      checkOutput($sformatf("t3_rd_done_b%0d", k), 64'(rd_done), (k == 2) ? 64'h1 : 64'h0);
      nextCycle();
    end
    settle();
    checkOutput("t3_end_busy", 64'(busy), 64'd0);

    // Reset during beat 2 of a len=7 burst, then a fresh grant
    $display("[TB] reset mid-burst");
    grantRead(2'd0, 4'd3, 4'd7, 4'h1);
    settle();
    nextCycle();
    dropGrant();
    RREADY_M = 3'b001;
    applyStimulus(3, 1'b1, 32'hC0DE_0000, 1'b0, 8'h01);
    settle();
    checkOutput("t4_b0_rvalid", 64'(RVALID_M), 64'h1);
    nextCycle();
    nextCycle();
    ARESET = 1'b1;
    settle();
    checkOutput("t4_rst_rd_done", 64'(rd_done), 64'd0);
    checkOutput("t4_rst_rvalid", 64'(RVALID_M), 64'd0);
    nextCycle();
    ARESET = 1'b0;
    settle();
    checkOutput("t4_post_busy", 64'(busy), 64'd0);
    checkOutput("t4_post_rvalid", 64'(RVALID_M), 64'd0);
    checkOutput("t4_post_rready_s", 64'(RREADY_S), 64'd0);
    checkOutput("t4_post_rd_done", 64'(rd_done), 64'd0);
    grantRead(2'd1, 4'd3, 4'd0, 4'h3);
    applyStimulus(3, 1'b1, 32'h1234_5678, 1'b1, 8'h13);
    RREADY_M = 3'b010;
    settle();
    nextCycle();
    dropGrant();
    settle();
    checkOutput("t4_new_busy", 64'(busy), 64'd1);
    checkOutput("t4_new_rvalid", 64'(RVALID_M), 64'h2);
    checkOutput("t4_new_rdata", 64'(RDATA_M[63:32]), 64'h1234_5678);
    checkOutput("t4_new_rready_s", 64'(RREADY_S), 64'h08);
    checkOutput("t4_new_rd_done", 64'(rd_done), 64'd1);
    nextCycle();
    applyStimulus(3, 1'b0, 32'h0, 1'b0, 8'h00);
    settle();
    checkOutput("t4_end_busy", 64'(busy), 64'd0);

    // Back-to-back len=0 bursts: M0->S2 then M1->S0
    $display("[TB] back-to-back len=0 bursts");
    grantRead(2'd0, 4'd2, 4'd0, 4'h5);
    settle();
    nextCycle();
    grantRead(2'd1, 4'd0, 4'd0, 4'h6);
    applyStimulus(2, 1'b1, 32'h0000_00C0, 1'b1, 8'h05);
    applyStimulus(0, 1'b1, 32'h0000_00E0, 1'b1, 8'h16);
    RREADY_M = 3'b111;
    settle();
    checkOutput("t5_a_rd_done", 64'(rd_done), 64'd1);
    checkOutput("t5_a_rvalid", 64'(RVALID_M), 64'h1);
    checkOutput("t5_a_rdata", 64'(RDATA_M[31:0]), 64'h0000_00C0);
    checkOutput("t5_a_rready_s", 64'(RREADY_S), 64'h04);
    checkOutput("t5_a_rid", 64'(RID_M[3:0]), 64'h5);
    nextCycle();
    settle();
    checkOutput("t5_gap_busy", 64'(busy), 64'd0);
    checkOutput("t5_gap_rd_done", 64'(rd_done), 64'd0);
    checkOutput("t5_gap_rvalid", 64'(RVALID_M), 64'd0);
    checkOutput("t5_gap_rready_s", 64'(RREADY_S), 64'd0);
    applyStimulus(2, 1'b0, 32'h0, 1'b0, 8'h00);
    nextCycle();
    dropGrant();
    settle();
    checkOutput("t5_b_rd_done", 64'(rd_done), 64'd1);
    checkOutput("t5_b_rvalid", 64'(RVALID_M), 64'h2);
    checkOutput("t5_b_rdata", 64'(RDATA_M[63:32]), 64'h0000_00E0);
    checkOutput("t5_b_rready_s", 64'(RREADY_S), 64'h01);
    checkOutput("t5_b_rid", 64'(RID_M[7:4]), 64'h6);
    nextCycle();
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 8'h00);
    settle();
    checkOutput("t5_end_busy", 64'(busy), 64'd0);

`ifdef BURST_CHECK_EN
    // Early RLAST on beat 1 of a len=2 burst, then a burst whose RLAST never comes
    $display("[TB] burst length checking");
    checkOutput("t6_len_err_init", 64'(len_err), 64'd0);
    grantRead(2'd0, 4'd1, 4'd2, 4'h4);
    settle();
    nextCycle();
    dropGrant();
    applyStimulus(1, 1'b1, 32'hF000_0000, 1'b0, 8'h04);
    settle();
    checkOutput("t6_early_b0_rd_done", 64'(rd_done), 64'd0);
    nextCycle();
    applyStimulus(1, 1'b1, 32'hF000_0001, 1'b1, 8'h04);
    settle();
    checkOutput("t6_early_b1_rlast", 64'(RLAST_M), 64'h1);
    checkOutput("t6_early_b1_rd_done", 64'(rd_done), 64'd1);
    nextCycle();
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 8'h00);
    settle();
    checkOutput("t6_early_busy", 64'(busy), 64'd0);
    checkOutput("t6_early_len_err", 64'(len_err), 64'd1);
    grantRead(2'd1, 4'd1, 4'd2, 4'h8);
    settle();
    nextCycle();
    dropGrant();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1'b1, 32'hF100_0000 + 32'(k), 1'b0, 8'h18);
      settle();
      checkOutput($sformatf("t6_miss_rlast_b%0d", k), 64'(RLAST_M), (k == 2) ? 64'h2 : 64'h0);
      checkOutput($sformatf("t6_miss_rd_done_b%0d", k), 64'(rd_done), (k == 2) ? 64'h1 : 64'h0);
      nextCycle();
    end
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 8'h00);
    settle();
    checkOutput("t6_miss_busy", 64'(busy), 64'd0);
    checkOutput("t6_len_err_sticky", 64'(len_err), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
